// File: rtl/frame_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_scan_ctrl
// Brief    : Raster-scan sequencer for one IMG_W x IMG_H frame with
//            KSIZE x KSIZE window, line and frame completion flags.
// Revision : 1.0 - initial release
// ============================================================================
module frame_scan_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 640,
    parameter int KSIZE = 3,
    parameter int CW    = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          acc_valid,
    output logic [CW-1:0] acc_col,
    output logic [CW-1:0] acc_row,
    output logic          win_valid,
    output logic          line_end,
    output logic [CW-1:0] lines_done,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_LAST_COL     = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_LAST_ROW     = CW'(IMG_H - 1);
    localparam logic [CW-1:0] C_WIN_MIN      = CW'(KSIZE - 1);
    localparam logic [CW-1:0] C_PRE_LAST_ROW = CW'((KSIZE > 1) ? (KSIZE - 2) : 0);
    // A 1x1 kernel has no rows to prefill, so the scan starts directly in RUN.
    localparam state_t        C_FIRST_STATE  = (KSIZE == 1) ? S_RUN : S_PREFILL;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_lines_done;
    logic          r_acc_valid;
    logic [CW-1:0] r_acc_col;
    logic [CW-1:0] r_acc_row;
    logic          r_win_valid;
    logic          r_line_end;

    logic          w_busy;
    logic          w_accept;
    logic          w_last_col;
    logic          w_frame_start;

    assign w_busy        = (r_state == S_PREFILL) || (r_state == S_RUN);
    assign pix_ready     = w_busy & ~stall & ~abort;
    assign w_accept      = pix_valid & pix_ready;
    assign w_last_col    = (r_col == C_LAST_COL);
    assign w_frame_start = (r_state == S_IDLE) & start & ~abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = C_FIRST_STATE;
                end
            end
            S_PREFILL: begin
                if (w_accept && w_last_col && (r_row == C_PRE_LAST_ROW)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_last_col && (r_row == C_LAST_ROW)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides every transition, including a start in IDLE.
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_lines_done <= '0;
        end else if (w_frame_start) begin
            r_col        <= '0;
            r_row        <= '0;
            r_lines_done <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col        <= '0;
                r_row        <= r_row + CW'(1);
                r_lines_done <= r_lines_done + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Report stage: flags describe the pixel at its pre-increment position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_valid <= 1'b0;
            r_acc_col   <= '0;
            r_acc_row   <= '0;
            r_win_valid <= 1'b0;
            r_line_end  <= 1'b0;
        end else begin
            r_acc_valid <= w_accept;
            r_win_valid <= w_accept && (r_row >= C_WIN_MIN) && (r_col >= C_WIN_MIN);
            r_line_end  <= w_accept && w_last_col;
            if (w_accept) begin
                r_acc_col <= r_col;
                r_acc_row <= r_row;
            end
        end
    end

    assign acc_valid  = r_acc_valid;
    assign acc_col    = r_acc_col;
    assign acc_row    = r_acc_row;
    assign win_valid  = r_win_valid;
    assign line_end   = r_line_end;
    assign lines_done = r_lines_done;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/frame_scan_ctrl.md
Name: frame_scan_ctrl

Overview:
- Raster-scan sequencer for one IMG_W x IMG_H feature-map frame feeding the convolution line-buffer/window datapath.
- Accepts pixels from the upstream stream under a valid/ready handshake and tracks column/row position.
- Flags when a full KSIZE x KSIZE window is available, and reports line and frame completion to the layer scheduler.
- Sits between the pixel source and the line buffers; replaces free-running per-line counting with a start/busy/done controlled scan.

Parameters:
- IMG_W, 640, pixels per line (>= KSIZE)
- IMG_H, 640, lines per frame (>= KSIZE)
- KSIZE, 3, convolution window height/width (>= 1)
- CW, 15, width of coordinate and line-count outputs

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- abort  in  1  terminate the current frame; returns to IDLE
- stall  in  1  downstream back-pressure; while 1, no pixel is accepted
- pix_valid  in  1  upstream pixel present
- pix_ready  out  1  controller accepts a pixel this cycle (combinational)
- acc_valid  out  1  registered pulse, one cycle after each accepted pixel
- acc_col  out  CW  column of the pixel flagged by acc_valid
- acc_row  out  CW  row of the pixel flagged by acc_valid
- win_valid  out  1  qualifies acc_valid: a full KSIZE x KSIZE window ends at (acc_row, acc_col)
- line_end  out  1  qualifies acc_valid: pixel is the last of its line
- lines_done  out  CW  number of completed lines in the current frame
- busy  out  1  high in PREFILL and RUN
- done  out  1  one-cycle pulse when the frame's last pixel has been accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; internal col/row=0.
  - acc_valid, win_valid, line_end, done, busy = 0; acc_col, acc_row, lines_done = 0.
- Accept condition:
  - pix_ready = busy & ~stall & ~abort.
  - A pixel is accepted when pix_valid & pix_ready.
- States:
  - IDLE: start=1 -> PREFILL (or RUN if KSIZE==1); clear col, row, lines_done.
  - PREFILL: accepts rows 0..KSIZE-2; win_valid never asserted. Accepting the last pixel of row KSIZE-2 -> RUN.
  - RUN: accepts remaining rows. Accepting pixel (IMG_H-1, IMG_W-1) -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, pix_ready=0; -> IDLE next cycle.
- Position update on each accept:
  - If col == IMG_W-1: col=0, row=row+1, lines_done=lines_done+1 (same edge as the acc_valid for that pixel).
  - Otherwise: col=col+1.
  - No change while the handshake is not satisfied (stall or pix_valid=0 holds position indefinitely).
- Output timing (latency 1 cycle from accept edge):
  - acc_valid=1 with acc_col/acc_row = pre-increment position.
  - win_valid = (row >= KSIZE-1) & (col >= KSIZE-1) for that pixel.
  - line_end = (col == IMG_W-1).
  - All three are 0 whenever acc_valid=0.
  - acc_col/acc_row hold their last value when acc_valid=0.
- done asserts in the cycle after the final pixel's accept edge, coincident with that pixel's acc_valid. lines_done = IMG_H at that point and holds until the next start.
- start in PREFILL/RUN/DONE is ignored (no restart, no position change).
- abort:
  - Takes effect from any state: pix_ready=0 in the same cycle; next edge -> IDLE.
  - done is not pulsed.
  - A pending acc_valid from the previous accept still emits.
  - abort and start together in IDLE: abort wins, stays IDLE.
- Reset mid-frame: immediate return to reset values; no done.
- Arithmetic: counters compare against IMG_W-1/IMG_H-1 only; no wrap beyond the frame. CW must hold IMG_H.

Test Plan:
- Default params, start, pix_valid=1, stall=0 for 409600 cycles -> exactly 409600 acc_valid pulses, 640 line_end pulses, one done pulse one cycle after the 409600th accept, lines_done=640, busy falls the same cycle done rises.
- IMG_W=4, IMG_H=4, KSIZE=3, continuous input -> win_valid only for (2,2),(2,3),(3,2),(3,3); PREFILL covers the first 8 accepts; acc_row/acc_col sequence strictly raster.
- IMG_W=4, IMG_H=3, random pix_valid and stall patterns -> pix_ready=0 whenever stall=1; position frozen across gaps; total accepts=12; done once.
- Abort asserted at accept #5 of a 4x3 frame -> pix_ready drops the same cycle, IDLE next cycle, no done. A new start rescans from (0,0) with lines_done cleared.
- start pulsed during RUN; start and abort together in IDLE -> no effect on position or state in either case.
- reset driven low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately; after release, start gives a normal full frame.
